// File: rtl/tinychip_pkg.sv
// Shared TinyChip definitions: PC sequencer state encoding and default widths.
package tinychip_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    UPDATE = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } seq_state_t;

  localparam int unsigned DEF_RETIRE_W      = 16;
  localparam int unsigned DEF_FETCH_TIMEOUT = 15;
  localparam int unsigned DEF_CNT_W         = 4;

  function automatic logic seq_busy(input seq_state_t s);
    return s inside {FETCH, DECODE, EXEC, MEM, UPDATE};
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM stepping the TinyChip PC once per retired instruction.
// All outputs are flops loaded from the next-state decode, so they are Moore in the state they describe.
module pc_sequencer
  import tinychip_pkg::*;
#(
  parameter int unsigned RETIRE_W      = DEF_RETIRE_W,
  parameter int unsigned FETCH_TIMEOUT = DEF_FETCH_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                instr_ready,
  input  logic                dec_jump,
  input  logic                dec_branch,
  input  logic                dec_mem,
  input  logic                dec_halt,
  input  logic                branch_cond,
  input  logic                mem_done,
  output logic                instr_req,
  output logic                ir_load,
  output logic                pc_en,
  output logic                pc_write,
  output logic                pc_do_branch,
  output logic                pc_reset,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retired
);

  seq_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_jump, r_branch, r_mem, r_taken;
  logic                r_instr_req, r_ir_load, r_pc_en, r_pc_write, r_pc_do_branch;
  logic                r_pc_reset, r_busy, r_done, r_fault;

  seq_state_t w_state_nxt;
  logic       w_start_ok;
  logic       w_taken_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    unique case (r_state)
      IDLE, HALT, FAULT: begin
        if (start) begin
          w_state_nxt = FETCH;
          w_start_ok  = 1'b1;
        end
      end
      FETCH: begin
        // A ready arriving in the final allowed cycle still wins over the timeout.
        if (instr_ready)                              w_state_nxt = DECODE;
        else if (r_cnt == CNT_W'(FETCH_TIMEOUT - 1))  w_state_nxt = FAULT;
      end
      DECODE:  w_state_nxt = dec_halt ? HALT : EXEC;
      EXEC:    w_state_nxt = r_mem ? MEM : UPDATE;
      MEM:     if (mem_done) w_state_nxt = UPDATE;
      UPDATE:  w_state_nxt = FETCH;
      default: w_state_nxt = IDLE;
    endcase
    w_taken_nxt = (r_state == EXEC) ? (r_branch & branch_cond) : r_taken;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_retired      <= '0;
      r_jump         <= 1'b0;
      r_branch       <= 1'b0;
      r_mem          <= 1'b0;
      r_taken        <= 1'b0;
      r_instr_req    <= 1'b0;
      r_ir_load      <= 1'b0;
      r_pc_en        <= 1'b0;
      r_pc_write     <= 1'b0;
      r_pc_do_branch <= 1'b0;
      r_pc_reset     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == FETCH && w_state_nxt == FETCH) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == DECODE) begin
        r_jump   <= dec_jump;
        r_branch <= dec_branch;
        r_mem    <= dec_mem;
      end
      r_taken <= w_taken_nxt;

      if (w_start_ok)
        r_retired <= '0;
      else if (r_state == UPDATE && r_retired != '1)
        r_retired <= r_retired + RETIRE_W'(1);

      r_instr_req    <= (w_state_nxt == FETCH);
      r_ir_load      <= (r_state == FETCH) && instr_ready;
      r_pc_en        <= (w_state_nxt == UPDATE);
      // Jump outranks a taken branch, so the two PC strobes are exclusive.
      r_pc_write     <= (w_state_nxt == UPDATE) && r_jump;
      r_pc_do_branch <= (w_state_nxt == UPDATE) && !r_jump && w_taken_nxt;
      r_pc_reset     <= w_start_ok;
      r_busy         <= seq_busy(w_state_nxt);
      r_done         <= (w_state_nxt == HALT);
      r_fault        <= (w_state_nxt == FAULT);
    end
  end

  assign instr_req    = r_instr_req;
  assign ir_load      = r_ir_load;
  assign pc_en        = r_pc_en;
  assign pc_write     = r_pc_write;
  assign pc_do_branch = r_pc_do_branch;
  assign pc_reset     = r_pc_reset;
  assign busy         = r_busy;
  assign done         = r_done;
  assign fault        = r_fault;
  assign state_o      = r_state;
  assign retired      = r_retired;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM that sequences the TinyChip program counter.
- Handles instruction fetch over a req/ready handshake, waits on decode and data memory, and decides per instruction whether the PC increments, jumps or takes a LUT branch.
- Drives the PC's write/do_branch inputs plus a pc_en gate so the PC advances exactly once per retired instruction.
- Sits between instruction memory, decoder, ALU flags and the program counter.

Parameters:
- RETIRE_W, 16, width of retired-instruction counter (saturating).
- FETCH_TIMEOUT, 15, max FETCH cycles waiting for instr_ready before FAULT (>=1).
- CNT_W, 4, width of fetch timeout counter; must hold FETCH_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse: begin execution (IDLE, HALT or FAULT only).
- instr_ready  in  1  instruction memory data valid for current PC.
- dec_jump  in  1  decoded instruction is an absolute jump.
- dec_branch  in  1  decoded instruction is a conditional LUT branch.
- dec_mem  in  1  decoded instruction accesses data memory.
- dec_halt  in  1  decoded instruction is halt.
- branch_cond  in  1  ALU condition flag, valid in EXEC.
- mem_done  in  1  data memory access complete.
- instr_req  out  1  fetch request to instruction memory.
- ir_load  out  1  load instruction register.
- pc_en  out  1  PC updates this cycle.
- pc_write  out  1  PC takes jump target (to PC write).
- pc_do_branch  out  1  PC takes LUT target (to PC do_branch).
- pc_reset  out  1  synchronous restart pulse to PC (PC returns to 0).
- busy  out  1  FSM not in IDLE/HALT/FAULT.
- done  out  1  halt reached; held until start/reset.
- fault  out  1  fetch timeout; held until start/reset.
- state_o  out  3  current state encoding (debug).
- retired  out  RETIRE_W  instructions retired since last start, saturating.

Behaviour:
- Reset (async): state=IDLE, retired=0, timeout cnt=0; all outputs 0. Reset mid-instruction abandons it; no PC strobe emitted.
- States: IDLE, FETCH, DECODE, EXEC, MEM, UPDATE, HALT, FAULT. Outputs are Moore, decoded from registered state and registered flags.
- IDLE/HALT/FAULT + start: pc_reset=1 for that cycle, retired<=0, done/fault<=0, go FETCH. start in any other state is ignored.
- FETCH: instr_req=1. instr_ready=1 -> ir_load=1, cnt<=0, go DECODE. Otherwise cnt++; if cnt reaches FETCH_TIMEOUT-1 while not ready -> FAULT. instr_ready in the same cycle as the timeout wins (goes DECODE).
- DECODE: one cycle. Latch dec_* flags. dec_halt -> HALT (PC not advanced, retired not incremented). Else go EXEC.
- EXEC: one cycle. Latch taken = dec_branch & branch_cond. dec_mem -> MEM, else UPDATE.
- MEM: wait for mem_done; mem_done=1 -> UPDATE. There is no timeout here.
- UPDATE: pc_en=1, retired++ (saturates at all-ones), go FETCH. Select one PC action with priority jump > taken branch > increment:
  - jump: pc_write=1
  - taken branch: pc_do_branch=1
  - otherwise: pc_write=pc_do_branch=0
- Never assert pc_write and pc_do_branch together.
- HALT: done=1. FAULT: fault=1. Both are sticky until start.
- Latency per instruction: 4 cycles min (FETCH, DECODE, EXEC, UPDATE) with instr_ready already high; +1 per FETCH wait; +MEM cycles (>=1) for memory ops.
- busy=1 in FETCH..UPDATE.

Decomposition:
- tinychip_pkg: seq_state_t enum (IDLE=0, FETCH, DECODE, EXEC, MEM, UPDATE, HALT, FAULT) and default width constants.
- No sub-module; the retire counter and timeout counter live inline.

Test Plan:
- Reset then start, instr_ready tied 1, 3 plain ALU instrs then halt -> pc_en pulses on cycles 4/8/12 after start, retired=3, done=1, busy=0.
- dec_branch=1 with branch_cond=1, then with branch_cond=0 -> first UPDATE has pc_do_branch=1/pc_write=0; second has both 0, pc_en=1.
- dec_jump=1 and dec_branch=1 with cond=1 -> UPDATE asserts pc_write only.
- dec_mem=1 with mem_done delayed 5 cycles -> FSM holds MEM 5 cycles; single pc_en pulse; retired+1.
- instr_ready held 0 for FETCH_TIMEOUT cycles -> fault=1 and state FAULT; start -> pc_reset pulse, fault clears, FETCH.
- Assert reset during MEM -> all outputs 0 immediately; start ignored while busy; retired saturates at 0xFFFF on long run.
